// File: rtl/stb_pkg.sv
// Shared types for the committed-store buffer: FSM states, entry layout and pointer width.
package stb_pkg;

    localparam int STB_DEPTH  = 4;
    localparam int STB_ADDR_W = 64;
    localparam int STB_DATA_W = 64;
    localparam int STB_PTR_W  = $clog2(STB_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } stb_state_e;

    typedef struct packed {
        logic [STB_ADDR_W-1:0] addr;
        logic [STB_DATA_W-1:0] data;
        logic [2:0]            size;
    } stb_entry_t;

endpackage

// File: rtl/stb_fifo.sv
// Circular store buffer: entry storage, head/tail pointers, occupancy count and
// a per-slot valid vector so the owner can scan live entries.
module stb_fifo
    import stb_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int PTR_W = STB_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushEn_i,
    input  stb_entry_t       pushEntry_i,
    input  logic             popEn_i,
    output stb_entry_t       headEntry_o,
    output stb_entry_t       entries_o [DEPTH],
    output logic [DEPTH-1:0] entryValid_o,
    output logic [PTR_W:0]   count_o
);

    stb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] headPtr_q;
    logic [PTR_W-1:0] tailPtr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] slotOffset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            if (pushEn_i) tailPtr_q <= tailPtr_q + 1'b1;
            if (popEn_i)  headPtr_q <= headPtr_q + 1'b1;
            case ({pushEn_i, popEn_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: a slot is only observed while it is marked valid.
    always_ff @(posedge clk) begin
        if (pushEn_i) mem_q[tailPtr_q] <= pushEntry_i;
    end

    always_comb begin
        slotOffset   = '0;
        entryValid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slotOffset      = PTR_W'(i) - headPtr_q;
            entryValid_o[i] = ({1'b0, slotOffset} < count_q);
        end
    end

    assign headEntry_o = mem_q[headPtr_q];
    assign entries_o   = mem_q;
    assign count_o     = count_q;

endmodule

// File: rtl/dcache_store_drain_ctrl.sv
// D-cache committed-store drain controller: buffers commit stores and issues them one at a
// time to memory, with flush sequencing. Load-address conflict check enabled by STB_LD_CONFLICT_EN.
module dcache_store_drain_ctrl
    import stb_pkg::*;
#(
    parameter int DEPTH  = STB_DEPTH,
    parameter int ADDR_W = STB_ADDR_W,
    parameter int DATA_W = STB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stEn_i,
    input  logic [ADDR_W-1:0] stAddr_i,
    input  logic [DATA_W-1:0] stData_i,
    input  logic [2:0]        stSize_i,
    output logic              stallStCommit_o,
    output logic              stOverflow_o,
    output logic              dc2memStValid_o,
    output logic [ADDR_W-1:0] dc2memStAddr_o,
    output logic [DATA_W-1:0] dc2memStData_o,
    output logic [2:0]        dc2memStSize_o,
    input  logic              mem2dcStStall_i,
    input  logic              mem2dcStComplete_i,
    input  logic              dcFlush_i,
    output logic              dcFlushDone_o,
    input  logic [ADDR_W-1:0] ldAddr_i,
    output logic              ldConflict_o
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    stb_state_e       state_q;
    logic             flushPending_q;
    logic             flushDone_q;
    logic             overflow_q;

    stb_entry_t       pushEntry;
    stb_entry_t       headEntry;
    stb_entry_t       entries [DEPTH];
    logic [DEPTH-1:0] entryValid;
    logic [PTR_W:0]   count;
    logic             pushEn;
    logic             popEn;
    logic             unusedSink;

    assign stallStCommit_o = (count == FULL_CNT) | flushPending_q;
    assign pushEn          = stEn_i & ~stallStCommit_o;
    assign popEn           = (state_q == WAIT) & mem2dcStComplete_i;

    assign pushEntry.addr = stAddr_i;
    assign pushEntry.data = stData_i;
    assign pushEntry.size = stSize_i;

    stb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .pushEn_i     (pushEn),
        .pushEntry_i  (pushEntry),
        .popEn_i      (popEn),
        .headEntry_o  (headEntry),
        .entries_o    (entries),
        .entryValid_o (entryValid),
        .count_o      (count)
    );

    // Memory stall only gates the launch from IDLE; once issued, the store runs to completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            flushPending_q <= 1'b0;
            flushDone_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            flushDone_q <= 1'b0;
            case (state_q)
                IDLE:    if ((count != '0) && !mem2dcStStall_i) state_q <= ISSUE;
                ISSUE:   state_q <= WAIT;
                WAIT:    if (mem2dcStComplete_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (flushPending_q && (count == '0) && (state_q == IDLE)) begin
                flushDone_q    <= 1'b1;
                flushPending_q <= 1'b0;
            end else if (dcFlush_i) begin
                flushPending_q <= 1'b1;
            end
            if (stEn_i && stallStCommit_o) overflow_q <= 1'b1;
        end
    end

    assign dc2memStValid_o = (state_q == ISSUE);
    assign dc2memStAddr_o  = dc2memStValid_o ? headEntry.addr : '0;
    assign dc2memStData_o  = dc2memStValid_o ? headEntry.data : '0;
    assign dc2memStSize_o  = dc2memStValid_o ? headEntry.size : '0;
    assign dcFlushDone_o   = flushDone_q;
    assign stOverflow_o    = overflow_q;

`ifdef STB_LD_CONFLICT_EN
    // Doubleword-granular match; the in-flight head stays valid until its complete pops it.
    always_comb begin
        ldConflict_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entries[i].addr[ADDR_W-1:3] == ldAddr_i[ADDR_W-1:3]))
                ldConflict_o = 1'b1;
        end
    end
`else
    assign ldConflict_o = 1'b0;
`endif

    always_comb begin
        unusedSink = ^ldAddr_i;
        for (int i = 0; i < DEPTH; i++)
            unusedSink = unusedSink ^ entryValid[i] ^ (^entries[i]);
    end

endmodule

// File: tb/tb_dcache_store_drain_ctrl.sv
// Scoreboard bench for dcache_store_drain_ctrl: expected stores queued on enqueue and
// compared when the DUT pulses its memory request; flush/reset/stall timing checked inline.
module tb_dcache_store_drain_ctrl;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  size;
    } exp_t;

`ifdef STB_LD_CONFLICT_EN
    localparam logic EXP_HIT = 1'b1;
`else
    localparam logic EXP_HIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stEn = 1'b0;
    logic [63:0] stAddr = '0;
    logic [63:0] stData = '0;
    logic [2:0]  stSize = '0;
    logic        memStall = 1'b0;
    logic        memComplete;
    logic        dcFlush = 1'b0;
    logic [63:0] ldAddr = '0;
    logic        stall, overflow, valid, done, conflict;
    logic [63:0] mAddr, mData;
    logic [2:0]  mSize;

    exp_t expQ[$];
    int   testCount = 0;
    int   failCount = 0;
    int   validCount = 0;
    int   doneCount = 0;
    int   cycleCnt = 0;
    int   lastCompleteCycle = 0;
    int   doneGap = 0;
    logic autoComplete = 1'b0;
    int   respLat = 3;
    int   cd = 0;
    logic completeResp = 1'b0;
    logic completeForce = 1'b0;
    int   v0, d0;

    assign memComplete = completeResp | completeForce;

    dcache_store_drain_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .stEn_i             (stEn),
        .stAddr_i           (stAddr),
        .stData_i           (stData),
        .stSize_i           (stSize),
        .stallStCommit_o    (stall),
        .stOverflow_o       (overflow),
        .dc2memStValid_o    (valid),
        .dc2memStAddr_o     (mAddr),
        .dc2memStData_o     (mData),
        .dc2memStSize_o     (mSize),
        .mem2dcStStall_i    (memStall),
        .mem2dcStComplete_i (memComplete),
        .dcFlush_i          (dcFlush),
        .dcFlushDone_o      (done),
        .ldAddr_i           (ldAddr),
        .ldConflict_o       (conflict)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cycleCnt = cycleCnt + 1;
        if (memComplete) lastCompleteCycle = cycleCnt;
    end

    // Scoreboard: every request pulse must match the oldest accepted store.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            validCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpValid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("reqAddr", mAddr, e.addr);
                checkOutput("reqData", mData, e.data);
                checkOutput("reqSize", {61'd0, mSize}, {61'd0, e.size});
            end
        end
        if (done === 1'b1) begin
            doneCount++;
            doneGap = cycleCnt - lastCompleteCycle;
        end
    end

    // Memory model: completes each request respLat cycles after its pulse.
    always @(negedge clk) begin
        completeResp = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) completeResp = 1'b1;
        end
        if ((valid === 1'b1) && autoComplete) cd = respLat;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] d, input logic [2:0] s,
                                 input bit accept);
        exp_t e;
        stEn   = 1'b1;
        stAddr = a;
        stData = d;
        stSize = s;
        if (accept) begin
            e.addr = a;
            e.data = d;
            e.size = s;
            expQ.push_back(e);
        end
        step();
        stEn = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (expQ.size() == 0) break;
            step();
        end
        if (expQ.size() != 0) checkOutput(tag, 64'd1, 64'd0);
        repeat (8) step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 reset = 1'b1;
        repeat (2) step();
        checkOutput("rstStall", {63'd0, stall}, 64'd0);
        checkOutput("rstOverflow", {63'd0, overflow}, 64'd0);
        checkOutput("rstValid", {63'd0, valid}, 64'd0);
        checkOutput("rstAddr", mAddr, 64'd0);
        checkOutput("rstData", mData, 64'd0);
        checkOutput("rstSize", {61'd0, mSize}, 64'd0);
        checkOutput("rstDone", {63'd0, done}, 64'd0);
        checkOutput("rstConflict", {63'd0, conflict}, 64'd0);
        reset = 1'b0;
        step();

        // Single store, then flush on an empty buffer
        autoComplete = 1'b1;
        applyStimulus(64'h1000, 64'hAB, 3'd0, 1);
        checkOutput("t1NoValidYet", {63'd0, valid}, 64'd0);
        step();
        checkOutput("t1ValidPulse", {63'd0, valid}, 64'd1);
        step();
        checkOutput("t1ValidOnce", {63'd0, valid}, 64'd0);
        checkOutput("t1AddrGated", mAddr, 64'd0);
        repeat (6) step();
        dcFlush = 1'b1;
        step();
        dcFlush = 1'b0;
        checkOutput("t1FlushStall", {63'd0, stall}, 64'd1);
        checkOutput("t1DoneEarly", {63'd0, done}, 64'd0);
        step();
        checkOutput("t1FlushDone", {63'd0, done}, 64'd1);
        step();
        checkOutput("t1DoneOnce", {63'd0, done}, 64'd0);
        checkOutput("t1StallClear", {63'd0, stall}, 64'd0);

        // Fill and overflow
        autoComplete = 1'b0;
        v0 = validCount;
        for (int i = 0; i < 4; i++)
            applyStimulus(64'h3000 + 64'(i * 8), 64'hC0DE0000 + 64'(i), 3'(i), 1);
        checkOutput("t2FullStall", {63'd0, stall}, 64'd1);
        checkOutput("t2NoOverflowYet", {63'd0, overflow}, 64'd0);
        applyStimulus(64'hDEAD0, 64'hDEAD, 3'd7, 0);
        checkOutput("t2Overflow", {63'd0, overflow}, 64'd1);
        autoComplete  = 1'b1;
        completeForce = 1'b1;
        step();
        completeForce = 1'b0;
        waitDrain("t2DrainTimeout");
        checkOutput("t2DrainCount", 64'(validCount - v0), 64'd4);
        checkOutput("t2StallFree", {63'd0, stall}, 64'd0);
        checkOutput("t2OverflowSticky", {63'd0, overflow}, 64'd1);

        // Memory stall before issue and during an outstanding store
        memStall = 1'b1;
        v0 = validCount;
        applyStimulus(64'h4000, 64'h11, 3'd1, 1);
        applyStimulus(64'h4010, 64'h22, 3'd2, 1);
        repeat (8) step();
        checkOutput("t3NoValidInStall", 64'(validCount - v0), 64'd0);
        checkOutput("t3AddrZeroIdle", mAddr, 64'd0);
        checkOutput("t3DataZeroIdle", mData, 64'd0);
        memStall = 1'b0;
        step();
        checkOutput("t3ValidAfterStall", {63'd0, valid}, 64'd1);
        memStall = 1'b1;
        repeat (6) step();
        checkOutput("t3HeldBySecondStall", 64'(validCount - v0), 64'd1);
        memStall = 1'b0;
        step();
        checkOutput("t3SecondValid", {63'd0, valid}, 64'd1);
        waitDrain("t3DrainTimeout");

        // Flush with three buffered stores
        d0 = doneCount;
        applyStimulus(64'h5000, 64'h51, 3'd3, 1);
        applyStimulus(64'h5008, 64'h52, 3'd3, 1);
        applyStimulus(64'h5010, 64'h53, 3'd3, 1);
        dcFlush = 1'b1;
        step();
        dcFlush = 1'b0;
        checkOutput("t4FlushStall", {63'd0, stall}, 64'd1);
        for (int k = 0; k < 200; k++) begin
            if (doneCount != d0) break;
            step();
        end
        repeat (4) step();
        checkOutput("t4DoneOnce", 64'(doneCount - d0), 64'd1);
        checkOutput("t4DoneGap", 64'(doneGap), 64'd1);
        checkOutput("t4QueueEmpty", 64'(expQ.size()), 64'd0);
        checkOutput("t4StallClear", {63'd0, stall}, 64'd0);

        // Reset while a store is outstanding
        autoComplete = 1'b0;
        v0 = validCount;
        applyStimulus(64'h6000, 64'h66, 3'd3, 1);
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        checkOutput("t5RstValid", {63'd0, valid}, 64'd0);
        checkOutput("t5RstAddr", mAddr, 64'd0);
        checkOutput("t5RstOverflow", {63'd0, overflow}, 64'd0);
        checkOutput("t5RstStall", {63'd0, stall}, 64'd0);
        step();
        reset = 1'b0;
        completeForce = 1'b1;
        step();
        completeForce = 1'b0;
        dcFlush = 1'b1;
        step();
        dcFlush = 1'b0;
        step();
        checkOutput("t5EmptyFlushDone", {63'd0, done}, 64'd1);
        checkOutput("t5NoReissue", 64'(validCount - v0), 64'd1);

        // Load conflict
        autoComplete = 1'b1;
        memStall = 1'b1;
        applyStimulus(64'h2004, 64'h77, 3'd2, 1);
        ldAddr = 64'h2000;
        #1 checkOutput("t6ConflictHit", {63'd0, conflict}, {63'd0, EXP_HIT});
        ldAddr = 64'h2008;
        #1 checkOutput("t6ConflictMiss", {63'd0, conflict}, 64'd0);
        ldAddr = 64'h2000;
        memStall = 1'b0;
        step();
        checkOutput("t6IssueValid", {63'd0, valid}, 64'd1);
        checkOutput("t6InFlightHit", {63'd0, conflict}, {63'd0, EXP_HIT});
        waitDrain("t6DrainTimeout");
        checkOutput("t6ClearedAfterPop", {63'd0, conflict}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dcache_store_drain_ctrl.md
Name: dcache_store_drain_ctrl

Overview:
- Committed-store buffer and sequencer for the D-cache store-to-memory port.
- Accepts stores from commit, holds them in a small FIFO, and issues them one at a time on the dc2memSt* handshake.
- Honours mem2dcStStall_i and mem2dcStComplete_i, back-pressures commit through stallStCommit_o, and sequences dcFlush_i drain/done.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- ADDR_W, 64, store address width.
- DATA_W, 64, store data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- stEn_i  in  1  commit store enqueue request.
- stAddr_i  in  ADDR_W  store byte address.
- stData_i  in  DATA_W  store data, unaligned (LSB-justified).
- stSize_i  in  3  store size code.
- stallStCommit_o  out  1  commit must not enqueue.
- stOverflow_o  out  1  sticky: enqueue attempted while stalled.
- dc2memStValid_o  out  1  store request to memory, one-cycle pulse.
- dc2memStAddr_o  out  ADDR_W  head address.
- dc2memStData_o  out  DATA_W  head data.
- dc2memStSize_o  out  3  head size.
- mem2dcStStall_i  in  1  memory cannot accept a store this cycle.
- mem2dcStComplete_i  in  1  outstanding store finished.
- dcFlush_i  in  1  flush request pulse.
- dcFlushDone_o  out  1  one-cycle pulse when flush drain completes.
- ldAddr_i  in  ADDR_W  load address for conflict check.
- ldConflict_o  out  1  load overlaps a buffered store.

Behaviour:
- Reset (async, immediate):
  - FIFO empty, pointers and count 0, state IDLE, flushPending 0.
  - All outputs 0. Any outstanding store is dropped.
- Enqueue:
  - When stEn_i & ~stallStCommit_o, write {addr, data, size} at tail on the rising edge.
  - stallStCommit_o = (count == DEPTH) | flushPending; combinational from registers.
  - stEn_i while stallStCommit_o: entry discarded, stOverflow_o set until reset.
  - A simultaneous pop does not unblock enqueue in that same cycle.
- FSM states are IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when count > 0 & ~mem2dcStStall_i; stall is sampled only in IDLE.
  - ISSUE lasts exactly one cycle, then -> WAIT.
    - dc2memStValid_o = (state == ISSUE).
    - Addr, data and size are driven from the head entry; these fields are 0 whenever valid is low.
  - WAIT -> IDLE on mem2dcStComplete_i; head is popped on that edge.
  - mem2dcStComplete_i outside WAIT is ignored.
  - At most one store is outstanding.
- Latency:
  - Store enqueued at edge E into an empty buffer with no stall: valid high in the cycle after edge E+1.
  - Back-to-back throughput: complete at edge C gives next valid in the cycle after C+1.
- Ordering is strict FIFO. Pointer wrap-around uses log2(DEPTH) bits. Count is log2(DEPTH)+1 bits.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- Flush:
  - dcFlush_i sets flushPending.
  - When flushPending & count == 0 & state == IDLE, dcFlushDone_o pulses for one cycle and flushPending clears on the same edge.
  - Flush while already empty: done in the cycle after the following edge.
  - dcFlush_i while already pending: no additional effect.
- Entries persist through mispredict recovery; the block has no recovery input.

Optional Feature:
- Macro: STB_LD_CONFLICT_EN.
- Defined: ldConflict_o = OR over valid entries, including the in-flight head, of (entry.addr[ADDR_W-1:3] == ldAddr_i[ADDR_W-1:3]). This is combinational.
- Undefined: ldConflict_o tied 0 and ldAddr_i unused; the port list is unchanged.

Decomposition:
- Package stb_pkg holds:
  - the FSM state enum;
  - the stb_entry_t struct {addr, data, size};
  - the clog2-derived pointer-width constant.
- Sub-module stb_fifo holds entry storage, head/tail/count, and the per-entry valid vector used by the conflict check.
- The FSM, flush logic and outputs stay in the top level.

Test Plan:
- Single store:
  - Stimulus: enqueue addr 0x1000, data 0xAB, size 0 at edge 1.
  - Expected: valid pulse in the cycle after edge 2 carrying 0x1000/0xAB/0. Complete 3 cycles later gives count 0, FSM IDLE.
- Fill and stall:
  - Stimulus: 4 enqueues, no completes, then a 5th enqueue.
  - Expected: stallStCommit_o = 1 after the 4th. The 5th sets stOverflow_o = 1, and exactly 4 stores drain afterwards in order.
- Memory stall:
  - Stimulus: mem2dcStStall_i = 1 for 10 cycles with 2 stores buffered.
  - Expected: no valid during the stall. Valid in the 2nd cycle after stall drops. Stall rising during WAIT does not disturb the complete.
- Flush:
  - Stimulus: 3 stores buffered, dcFlush_i pulse.
  - Expected: stallStCommit_o = 1 immediately. Done pulses once, exactly one cycle after the 3rd complete edge. Flush on an empty buffer gives done 2 cycles after the pulse.
- Reset in WAIT:
  - Stimulus: assert reset mid-cycle while a store is outstanding.
  - Expected: outputs 0 immediately. A later mem2dcStComplete_i is ignored and count is 0.
- Load conflict (with STB_LD_CONFLICT_EN):
  - Stimulus: store at 0x2004 buffered.
  - Expected: ldAddr_i 0x2000 gives conflict 1, 0x2008 gives 0. Conflict clears after the pop. Without the macro, conflict is always 0.
